// File: rtl/cdb_arbiter_pkg.sv
// Shared types and helpers for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned NUM_CDB_SRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_B   = 2'd1,
    SRC_MEM = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic [6:0]  preg;
    logic [31:0] data;
    logic [4:0]  rob;
  } cdb_entry;

  // Distance of a tag from the ROB head; larger means younger.
  function automatic logic [4:0] rob_age(input logic [4:0] tag, input logic [4:0] head);
    return tag - head;
  endfunction

  function automatic logic rob_younger(input logic [4:0] tag, input logic [4:0] ref_tag,
                                       input logic [4:0] head);
    return rob_age(tag, head) > rob_age(ref_tag, head);
  endfunction

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source in-order result queue with push, head pop and age-based squash.
module cdb_src_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  cdb_entry   i_entry,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic [4:0] i_flush_tag,
  input  logic [4:0] i_rob_head,
  output logic       o_ready,
  output logic       o_head_valid,
  output cdb_entry   o_head
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  cdb_entry         r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  cdb_entry         w_mem_nxt [DEPTH];
  logic [CW-1:0]    w_count_nxt;

  assign o_ready      = (r_count < CW'(DEPTH));
  assign o_head_valid = (r_count != '0);
  assign o_head       = r_mem[0];

  // Rebuild the queue: drop popped head and squashed entries, compact, then append the push.
  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_mem_nxt[i] = r_mem[i];
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((CW'(i) < r_count) && !((i == 0) && i_pop) &&
          !(i_flush && rob_younger(r_mem[i].rob, i_flush_tag, i_rob_head))) begin
        w_mem_nxt[w_count_nxt] = r_mem[i];
        w_count_nxt            = w_count_nxt + CW'(1);
      end
    end
    // A younger push during a flush is accepted on the handshake but discarded.
    if (i_push && o_ready && !(i_flush && rob_younger(i_entry.rob, i_flush_tag, i_rob_head))) begin
      w_mem_nxt[w_count_nxt] = i_entry;
      w_count_nxt            = w_count_nxt + CW'(1);
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving one result per cycle from three source queues onto the CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  src_valid,
  output logic [2:0]  src_ready,
  input  logic [20:0] src_preg,
  input  logic [95:0] src_data,
  input  logic [14:0] src_rob,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag,
  input  logic [4:0]  rob_head,
  output logic        cdb_valid,
  output logic [6:0]  cdb_preg,
  output logic [31:0] cdb_data,
  output logic [4:0]  cdb_rob,
  output logic [1:0]  cdb_src
);

  cdb_entry   w_in_entry [NUM_CDB_SRC];
  cdb_entry   w_head     [NUM_CDB_SRC];
  logic [2:0] w_head_valid;
  logic [2:0] w_elig;
  logic [2:0] w_pop;
  logic       w_any;
  logic [1:0] w_gidx;
  logic [1:0] r_rr_ptr;

  for (genvar g = 0; g < int'(NUM_CDB_SRC); g++) begin : g_src
    assign w_in_entry[g] = {src_preg[7*g +: 7], src_data[32*g +: 32], src_rob[5*g +: 5]};
    // Heads younger than a flushing branch must not reach the bus.
    assign w_elig[g] = w_head_valid[g] &&
                       !(mispredict && rob_younger(w_head[g].rob, mispredict_tag, rob_head));
    assign w_pop[g]  = w_any && (w_gidx == 2'(g));

    cdb_src_queue #(
      .DEPTH(DEPTH)
    ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .i_push      (src_valid[g]),
      .i_entry     (w_in_entry[g]),
      .i_pop       (w_pop[g]),
      .i_flush     (mispredict),
      .i_flush_tag (mispredict_tag),
      .i_rob_head  (rob_head),
      .o_ready     (src_ready[g]),
      .o_head_valid(w_head_valid[g]),
      .o_head      (w_head[g])
    );
  end

  // Pick the first eligible head starting from the round-robin pointer.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    w_any  = 1'b0;
    w_gidx = 2'd0;
    for (int unsigned k = 0; k < NUM_CDB_SRC; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_CDB_SRC;
      if (!w_any && w_elig[idx]) begin
        w_any  = 1'b1;
        w_gidx = 2'(idx);
      end
    end
  end

  // Broadcast the granted head, or all zeros when nothing is granted.
  always_comb begin
    cdb_valid = w_any;
    cdb_src   = w_any ? w_gidx : 2'd0;
    cdb_preg  = w_any ? w_head[w_gidx].preg : 7'd0;
    cdb_data  = w_any ? w_head[w_gidx].data : 32'd0;
    cdb_rob   = w_any ? w_head[w_gidx].rob  : 5'd0;
  end

  // Advance priority past the winner; hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= SRC_ALU;
    end else if (w_any) begin
      r_rr_ptr <= (w_gidx == SRC_MEM) ? SRC_ALU : w_gidx + 2'd1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed literal checks.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_ready;
  logic [20:0] src_preg = '0;
  logic [95:0] src_data = '0;
  logic [14:0] src_rob = '0;
  logic        mispredict = 1'b0;
  logic [4:0]  mispredict_tag = '0;
  logic [4:0]  rob_head = '0;
  logic        cdb_valid;
  logic [6:0]  cdb_preg;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_rob;
  logic [1:0]  cdb_src;

  int n_chk = 0;
  int n_err = 0;

  cdb_entry    mq [3][$];
  int          m_rr = 0;
  logic [31:0] lsu_acc [$];
  logic [31:0] lsu_bcast [$];
  int          grants [$];

  cdb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_ready(src_ready),
    .src_preg(src_preg), .src_data(src_data), .src_rob(src_rob),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag), .rob_head(rob_head),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
    .cdb_rob(cdb_rob), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit young(input logic [4:0] t);
    logic [4:0] a, b;
    a = t - rob_head;
    b = mispredict_tag - rob_head;
    return a > b;
  endfunction

  function automatic int mgrant();
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_rr + k) % 3;
      if (mq[s].size() > 0 && !(mispredict && young(mq[s][0].rob))) return s;
    end
    return -1;
  endfunction

  function automatic cdb_entry in_entry(input int s);
    cdb_entry e;
    e.preg = src_preg[7*s +: 7];
    e.data = src_data[32*s +: 32];
    e.rob  = src_rob[5*s +: 5];
    return e;
  endfunction

  // Reference model: state advances on each clock edge, cleared by reset.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      m_rr = 0;
    end else begin
      int g;
      bit [2:0] rdy;
      g = mgrant();
      for (int i = 0; i < 3; i++) rdy[i] = mq[i].size() < DEPTH;
      if (g >= 0) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % 3;
      end
      if (mispredict) begin
        for (int i = 0; i < 3; i++) begin
          cdb_entry keep [$];
          keep = {};
          for (int j = 0; j < mq[i].size(); j++)
            if (!young(mq[i][j].rob)) keep.push_back(mq[i][j]);
          mq[i] = keep;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && rdy[i]) begin
          cdb_entry e;
          e = in_entry(i);
          if (!(mispredict && young(e.rob))) begin
            mq[i].push_back(e);
            if (i == 2) lsu_acc.push_back(e.data);
          end
        end
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  initial forever begin
    int g;
    logic [2:0] er;
    @(negedge clk);
    g = mgrant();
    for (int i = 0; i < 3; i++) er[i] = mq[i].size() < DEPTH;
    chk("src_ready", 64'(src_ready), 64'(er));
    chk("cdb_valid", 64'(cdb_valid), 64'(g >= 0));
    chk("cdb_src",   64'(cdb_src),   (g >= 0) ? 64'(g) : 64'd0);
    chk("cdb_preg",  64'(cdb_preg),  (g >= 0) ? 64'(mq[g][0].preg) : 64'd0);
    chk("cdb_data",  64'(cdb_data),  (g >= 0) ? 64'(mq[g][0].data) : 64'd0);
    chk("cdb_rob",   64'(cdb_rob),   (g >= 0) ? 64'(mq[g][0].rob) : 64'd0);
    if (cdb_valid) begin
      grants.push_back(int'(cdb_src));
      if (cdb_src == 2'd2) lsu_bcast.push_back(cdb_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [6:0] p, input logic [31:0] d,
                         input logic [4:0] r);
    src_preg[7*s +: 7]  = p;
    src_data[32*s +: 32] = d;
    src_rob[5*s +: 5]   = r;
  endtask

  task automatic reset_pulse();
    src_valid = '0;
    mispredict = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    step();
    step();
    @(negedge clk);
    #1;
    chk("rst_ready", 64'(src_ready), 64'h7);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
    step();
    reset = 1'b1;

    // Single ALU result, one-cycle latency
    set_src(0, 7'd5, 32'hDEADBEEF, 5'd3);
    src_valid = 3'b001;
    @(negedge clk);
    chk("lat0_valid", 64'(cdb_valid), 64'h0);
    step();
    src_valid = '0;
    @(negedge clk);
    chk("alu_valid", 64'(cdb_valid), 64'h1);
    chk("alu_preg",  64'(cdb_preg), 64'd5);
    chk("alu_data",  64'(cdb_data), 64'hDEADBEEF);
    chk("alu_rob",   64'(cdb_rob), 64'd3);
    chk("alu_src",   64'(cdb_src), 64'd0);
    step();
    @(negedge clk);
    chk("alu_after", 64'(cdb_valid), 64'h0);

    // Saturation: all sources push for 9 cycles
    step();
    reset_pulse();
    grants.delete();
    lsu_acc.delete();
    lsu_bcast.delete();
    for (int c = 0; c < 9; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, 7'(c*3+s), {16'(c), 16'(s)}, 5'(c*3+s));
      src_valid = 3'b111;
      @(negedge clk);
      if (c == 2) chk("sat_ready", 64'(src_ready), 64'b001);
      step();
    end
    src_valid = '0;
    for (int c = 0; c < 12; c++) step();
    for (int k = 0; k < 6; k++) chk($sformatf("rr_order%0d", k), 64'(grants[k]), 64'(k % 3));
    chk("lsu_count", 64'(lsu_bcast.size()), 64'(lsu_acc.size()));
    for (int k = 0; k < lsu_acc.size() && k < lsu_bcast.size(); k++)
      chk($sformatf("lsu_order%0d", k), 64'(lsu_bcast[k]), 64'(lsu_acc[k]));

    // Mispredict squash with ROB wraparound
    reset_pulse();
    rob_head = 5'd30;
    set_src(0, 7'd10, 32'h1111, 5'd31);
    set_src(1, 7'd11, 32'h2222, 5'd1);
    set_src(2, 7'd12, 32'h3333, 5'd4);
    src_valid = 3'b111;
    step();
    set_src(0, 7'd13, 32'h4444, 5'd2);
    src_valid = 3'b001;
    mispredict = 1'b1;
    mispredict_tag = 5'd1;
    @(negedge clk);
    chk("mp_rob0", 64'(cdb_rob), 64'd31);
    chk("mp_src0", 64'(cdb_src), 64'd0);
    step();
    src_valid = '0;
    mispredict = 1'b0;
    @(negedge clk);
    chk("mp_valid1", 64'(cdb_valid), 64'h1);
    chk("mp_rob1", 64'(cdb_rob), 64'd1);
    chk("mp_src1", 64'(cdb_src), 64'd1);
    step();
    @(negedge clk);
    chk("mp_empty", 64'(cdb_valid), 64'h0);
    rob_head = 5'd0;

    // Asynchronous reset mid-operation
    step();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 3; s++) set_src(s, 7'(40+c*3+s), 32'(100+c*3+s), 5'(c*3+s));
      src_valid = 3'b111;
      step();
    end
    src_valid = '0;
    @(negedge clk);
    chk("pre_rst_valid", 64'(cdb_valid), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(cdb_valid), 64'h0);
    chk("arst_ready", 64'(src_ready), 64'h7);
    chk("arst_data",  64'(cdb_data), 64'h0);
    chk("arst_preg",  64'(cdb_preg), 64'h0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("stale%0d", c), 64'(cdb_valid), 64'h0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries per source queue (legal values 1..4).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  one clock; reset is asynchronous and active-low (port named reset, asserted low).
REQ-004 src_valid  in  3  result offered; bit 0 = ALU, 1 = branch, 2 = LSU.
REQ-005 src_ready  out  3  per-source queue can accept.
REQ-006 src_preg  in  21  destination physical register, 7 bits per source, source i at [7i+6:7i].
REQ-007 src_data  in  96  result value, 32 bits per source.
REQ-008 src_rob  in  15  ROB tag, 5 bits per source.
REQ-009 mispredict  in  1  branch flush pulse.
REQ-010 mispredict_tag  in  5  ROB tag of the mispredicted branch.
REQ-011 rob_head  in  5  ROB tag of the oldest in-flight instruction, used as the age reference.
REQ-012 cdb_valid  out  1  broadcast valid; PRF write and wakeup strobe.
REQ-013 cdb_preg  out  7  broadcast physical register.
REQ-014 cdb_data  out  32  broadcast value.
REQ-015 cdb_rob  out  5  broadcast ROB tag.
REQ-016 cdb_src  out  2  granted source index (0..2).

Function
REQ-017 Each source SHALL own one in-order queue of DEPTH entries; src_ready[i] = (count_i < DEPTH), based on registered count only.
REQ-018 A push SHALL occur when src_valid[i] && src_ready[i]; a pop in the same cycle SHALL NOT raise src_ready while the queue is full.
REQ-019 The CDB SHALL be driven combinationally from the granted queue head; broadcast SHALL be in the cycle after acceptance at the earliest (1-cycle latency); the grant pops that head at the clock edge.
REQ-020 Exactly one head SHALL be granted per cycle whenever any eligible head exists; the bus consumer never stalls.
REQ-021 Arbitration SHALL be round-robin: register rr_ptr (2 bits, values 0..2) names the highest-priority source; after a grant to source g, rr_ptr = (g+1) mod 3; with no grant, rr_ptr SHALL hold.
REQ-022 When no head is eligible, cdb_valid = 0 and cdb_preg/cdb_data/cdb_rob/cdb_src = 0.
REQ-023 Age of tag t SHALL be (t - rob_head) mod 32; t is younger than mispredict_tag when age(t) > age(mispredict_tag).
REQ-024 In a cycle with mispredict = 1, every queued entry younger than mispredict_tag SHALL be removed at the edge; older or equal entries SHALL be retained in order, compacted toward the head.
REQ-025 In a mispredict cycle, younger heads SHALL be ineligible for grant; a younger incoming push SHALL be dropped, although src_ready still reports acceptance.
REQ-026 The branch's own result (tag == mispredict_tag) SHALL be retained and broadcast normally.
REQ-027 Entries SHALL never be duplicated, reordered within a source, or lost, except under REQ-024/025.

Reset
REQ-028 Asserting reset (low) SHALL immediately empty all queues, set rr_ptr = 0, and drive src_ready = 3'b111 and all cdb_* outputs to 0, including mid-operation.
REQ-029 After reset deasserts, the first grant SHALL follow rr_ptr = 0 priority (ALU first).

Structure
REQ-030 Shared package SHALL hold: the cdb_entry struct (preg 7, data 32, rob 5), the SRC_ALU/SRC_B/SRC_MEM enum, the NUM_CDB_SRC = 3 constant, and the rob_age() helper.
REQ-031 One sub-module, cdb_src_queue (DEPTH-entry queue with push, pop and age-based squash), SHALL be instantiated three times; the arbitration and rr_ptr logic SHALL live in cdb_arbiter.

Verification
REQ-032 ALU pushes preg 5, data 0xDEADBEEF, rob 3 alone -> next cycle cdb_valid = 1, cdb_preg = 5, cdb_data = 0xDEADBEEF, cdb_rob = 3, cdb_src = 0; the cycle after, cdb_valid = 0.
REQ-033 All three sources push every cycle for 9 cycles from reset -> grant order 0,1,2,0,1,2,...; src_ready drops to 0 on each source once its queue holds 2.
REQ-034 Fill LSU queue to DEPTH = 2 while ALU/branch saturate -> src_ready[2] = 0, no LSU push accepted, no LSU entry lost or reordered.
REQ-035 rob_head = 30, queued tags 31, 1, 4; mispredict with tag 1 -> tag 4 removed, tags 31 and 1 broadcast; a same-cycle incoming push with tag 2 is dropped.
REQ-036 Reset asserted with two entries in every queue -> all outputs 0 at once; after release, no stale entry is ever broadcast.
